miter_sequencer: RTL
====================

MITER_SEQUENCER -- requirements
Module: miter_sequencer

Interface
REQ-001 Parameter N_IN, default 2, width of the input vector driven to both circuits under test.
REQ-002 Parameter N_OUT, default 1, width of each circuit's output vector.
REQ-003 Parameter SETTLE, default 1, range 1..15, cycles a vector is held before outputs are compared.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 start  input  1  request a new exhaustive sweep.
REQ-007 ref_out  input  N_OUT  output of the golden circuit.
REQ-008 dut_out  input  N_OUT  output of the revised circuit.
REQ-009 vec_out  output  N_IN  vector driven to both circuits' inputs.
REQ-010 busy  output  1  sweep in progress.
REQ-011 done  output  1  sweep finished; result valid.
REQ-012 mismatch  output  1  at least one vector produced ref_out != dut_out.
REQ-013 fail_vec  output  N_IN  first vector that mismatched.
REQ-014 mismatch_cnt  output  N_IN+1  number of mismatching vectors (see REQ-030/031).

Function
REQ-015 The FSM SHALL have the states IDLE, SETTLE, CHECK and DONE.
REQ-016 In IDLE or DONE, start=1 SHALL, at edge E0, enter SETTLE, set vec_out=0, busy=1, done=0, mismatch=0, fail_vec=0 and mismatch_cnt=0, and load the settle counter with SETTLE-1.
REQ-017 In SETTLE, the block SHALL hold vec_out constant and decrement the counter each cycle, entering CHECK on the cycle after the counter reaches 0.
REQ-018 In CHECK, the block SHALL compare ref_out with dut_out over the full N_OUT width, combinationally sampled in that cycle.
REQ-019 On a CHECK mismatch with mismatch=0, the block SHALL set mismatch=1 and fail_vec=vec_out; later mismatches SHALL NOT change fail_vec.
REQ-020 If CHECK has no early-stop condition and vec_out != all-ones, the block SHALL increment vec_out, reload the counter and return to SETTLE.
REQ-021 If CHECK is on vec_out == all-ones, or an early stop applies, the block SHALL enter DONE with busy=0 and done=1; vec_out SHALL hold its last value and not wrap to 0.
REQ-022 Each vector SHALL take exactly SETTLE+1 cycles; a full sweep SHALL assert done at E0 + 2^N_IN*(SETTLE+1).
REQ-023 done, mismatch, fail_vec and mismatch_cnt SHALL hold in DONE until the next accepted start or reset.
REQ-024 start while busy=1 SHALL be ignored.
REQ-025 start in DONE SHALL restart the sweep per REQ-016, with no idle cycle in between.

Reset
REQ-026 rst=1 SHALL force IDLE on the next edge, from any state including mid-sweep.
REQ-027 After rst, vec_out, busy, done, mismatch, fail_vec, mismatch_cnt and the settle counter SHALL all be 0.
REQ-028 rst SHALL take priority over start in the same cycle.

Configuration
REQ-029 The feature SHALL be controlled by the macro MITER_SEQUENCER_COUNT_EN.
REQ-030 With MITER_SEQUENCER_COUNT_EN defined, the sweep SHALL always cover all 2^N_IN vectors, and mismatch_cnt SHALL increment by 1 on each mismatching CHECK; it cannot overflow, since the maximum is 2^N_IN.
REQ-031 Without the macro, the first mismatching CHECK SHALL enter DONE immediately (done at E0+(k+1)*(SETTLE+1) for vector k), and mismatch_cnt SHALL be tied to 0.

Verification
REQ-032 The bench SHALL cover these directed scenarios (N_IN=2, N_OUT=1, SETTLE=1):
- ref=NAND, dut=NAND, start pulse -> vec_out steps 00,01,10,11 every 2 cycles; done=1 at E0+8; mismatch=0.
- ref=NAND, dut=AND, macro off -> done at E0+2, mismatch=1, fail_vec=00.
- ref=NAND, dut differs only at 11, macro off -> done at E0+8, mismatch=1, fail_vec=11.
- ref=NAND, dut=AND, macro on -> done at E0+8, fail_vec=00, mismatch_cnt=4.
- rst at E0+3, then start pulses while busy=1 -> IDLE with all outputs 0; the start pulses during busy do not shorten or restart the sweep.
- start asserted in DONE -> a new sweep begins the next cycle with vec_out=00 and mismatch cleared.

Source files
------------

// File: rtl/miter_sequencer.sv
// rtl/miter_sequencer.sv - exhaustive input sweep comparing a golden and a revised circuit.
// MITER_SEQUENCER_COUNT_EN: sweep all vectors and count mismatches instead of stopping at the first.
module miter_sequencer #(
   parameter int N_IN   = 2,
   parameter int N_OUT  = 1,
   parameter int SETTLE = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [N_OUT-1:0]  ref_out,
   input  logic [N_OUT-1:0]  dut_out,
   output logic [N_IN-1:0]   vec_out,
   output logic              busy,
   output logic              done,
   output logic              mismatch,
   output logic [N_IN-1:0]   fail_vec,
   output logic [N_IN:0]     mismatch_cnt
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_SETTLE = 2'd1;
   localparam logic [1:0] S_CHECK  = 2'd2;
   localparam logic [1:0] S_DONE   = 2'd3;

   localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);

   logic [1:0]      state_q, state_d;
   logic [3:0]      scnt_q, scnt_d;
   logic [N_IN-1:0] vec_q, vec_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            mis_q, mis_d;
   logic [N_IN-1:0] fail_q, fail_d;
   logic            diff;
   logic            last_vec;
   logic            stop;
`ifdef MITER_SEQUENCER_COUNT_EN
   logic [N_IN:0]   mcnt_q, mcnt_d;
`endif

   assign diff     = (ref_out != dut_out);
   assign last_vec = (vec_q == {N_IN{1'b1}});

   always_comb begin
      state_d = state_q;
      scnt_d  = scnt_q;
      vec_d   = vec_q;
      busy_d  = busy_q;
      done_d  = done_q;
      mis_d   = mis_q;
      fail_d  = fail_q;
      stop    = 1'b0;
`ifdef MITER_SEQUENCER_COUNT_EN
      mcnt_d  = mcnt_q;
`endif
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d = S_SETTLE;
               scnt_d  = SETTLE_LOAD;
               vec_d   = '0;
               busy_d  = 1'b1;
               done_d  = 1'b0;
               mis_d   = 1'b0;
               fail_d  = '0;
`ifdef MITER_SEQUENCER_COUNT_EN
               mcnt_d  = '0;
`endif
            end
         end
         S_SETTLE: begin
            if (scnt_q == 4'd0) state_d = S_CHECK;
            else                scnt_d  = scnt_q - 4'd1;
         end
         default: begin
            if (diff && !mis_q) begin
               mis_d  = 1'b1;
               fail_d = vec_q;
            end
`ifdef MITER_SEQUENCER_COUNT_EN
            if (diff) mcnt_d = mcnt_q + (N_IN+1)'(1);
            stop = last_vec;
`else
            stop = last_vec || diff;
`endif
            // vec_out freezes on the final vector rather than wrapping
            if (stop) begin
               state_d = S_DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end else begin
               state_d = S_SETTLE;
               scnt_d  = SETTLE_LOAD;
               vec_d   = vec_q + N_IN'(1);
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         scnt_q  <= '0;
         vec_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         mis_q   <= 1'b0;
         fail_q  <= '0;
`ifdef MITER_SEQUENCER_COUNT_EN
         mcnt_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         scnt_q  <= scnt_d;
         vec_q   <= vec_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         mis_q   <= mis_d;
         fail_q  <= fail_d;
`ifdef MITER_SEQUENCER_COUNT_EN
         mcnt_q  <= mcnt_d;
`endif
      end
   end

   assign vec_out  = vec_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign mismatch = mis_q;
   assign fail_vec = fail_q;
`ifdef MITER_SEQUENCER_COUNT_EN
   assign mismatch_cnt = mcnt_q;
`else
   assign mismatch_cnt = '0;
`endif

endmodule
